// File: rtl/ov7670_dvp_pkg.sv
// Shared types and constants for the OV7670 DVP test-pattern transmitter.
package ov7670_dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  typedef enum logic [1:0] {
    RAMP_H,
    RAMP_V,
    CHECKER,
    SOLID_FCNT
  } pattern_t;

  // Chroma byte of every YUV422 pixel: neutral grey.
  localparam logic [7:0] CHROMA = 8'h80;

endpackage

// File: rtl/ov7670_dvp_tx_if.sv
// Control and pixel-bus bundle between the DVP transmitter (master) and its user.
interface ov7670_dvp_tx_if;

  logic       enable;
  logic [1:0] mode;
  logic       vsync;
  logic       href;
  logic [7:0] dout;
  logic [7:0] frame_cnt;
  logic       frame_done;
  logic       busy;

  modport master (
    input  enable, mode,
    output vsync, href, dout, frame_cnt, frame_done, busy
  );

  modport slave (
    output enable, mode,
    input  vsync, href, dout, frame_cnt, frame_done, busy
  );

endinterface

// File: rtl/ov7670_pattern_pixel.sv
// Combinational test-pattern byte generator: Y byte from the pattern, odd byte is chroma.
module ov7670_pattern_pixel
  import ov7670_dvp_pkg::*;
(
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic       byte_sel_i,
  input  pattern_t   mode_i,
  input  logic [7:0] frame_cnt_i,
  output logic [7:0] byte_o
);

  logic [7:0] y_val;

  // Pick the luma value for the current pattern, then substitute chroma on odd bytes.
  always_comb begin
    y_val = 8'h00;
    case (mode_i)
      RAMP_H:     y_val = x_i;
      RAMP_V:     y_val = y_i;
      CHECKER:    y_val = (x_i[3] ^ y_i[3]) ? 8'hFF : 8'h00;
      SOLID_FCNT: y_val = frame_cnt_i;
      default:    y_val = 8'h00;
    endcase
    byte_o = byte_sel_i ? CHROMA : y_val;
  end

endmodule

// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP source: VSYNC/HREF/D with VGA YUV422 frame timing and test patterns.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for enable
// VSYNC  | vsync high for v_sync_lines lines
// VBACK  | blank lines after vsync
// ACTIVE | active lines; href high for the first ACT bytes of each line
// VFRONT | blank lines after the active region; frame ends on its last cycle
//
// All outputs are a registered image of the current state/counters, so they
// trail the state register by one clock.
module ov7670_dvp_tx
  import ov7670_dvp_pkg::*;
#(
  parameter int h_active        = 640,
  parameter int h_blank         = 144,
  parameter int bytes_per_pixel = 2,
  parameter int v_sync_lines    = 3,
  parameter int v_back_lines    = 17,
  parameter int v_active        = 480,
  parameter int v_front_lines   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  ov7670_dvp_tx_if.master   dvp
);

  localparam int LINE = (h_active + h_blank) * bytes_per_pixel;
  localparam int ACT  = h_active * bytes_per_pixel;
  localparam int HW   = $clog2(LINE);
  // Line counter is sized generously; it only ever counts within one state.
  localparam int VW   = 16;

  function automatic int lines_of(state_t s);
    case (s)
      VSYNC:   return v_sync_lines;
      VBACK:   return v_back_lines;
      ACTIVE:  return v_active;
      VFRONT:  return v_front_lines;
      default: return 0;
    endcase
  endfunction

  // Frame-order successor; IDLE here marks "past the end of the frame".
  function automatic state_t succ(state_t s);
    case (s)
      VSYNC:   return VBACK;
      VBACK:   return ACTIVE;
      ACTIVE:  return VFRONT;
      default: return IDLE;
    endcase
  endfunction

  // First state at or after s with a non-zero line count, so empty states are skipped outright.
  function automatic state_t first_nonempty(state_t s);
    state_t r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (r != IDLE && lines_of(r) == 0) r = succ(r);
    end
    return r;
  endfunction

  localparam state_t FIRST_ST = first_nonempty(VSYNC);

  state_t          state_q;
  pattern_t        mode_q;
  logic [HW-1:0]   hcnt_q;
  logic [VW-1:0]   vcnt_q;
  logic [7:0]      frame_cnt_q;
  logic            vsync_q;
  logic            href_q;
  logic [7:0]      dout_q;
  logic            frame_done_q;
  logic            busy_q;

  logic            h_last;
  logic            v_last;
  state_t          nxt_st;
  logic            frame_end;
  logic            href_d;
  logic [7:0]      pix_x;
  logic [7:0]      pix_y;
  logic            byte_sel;
  logic [7:0]      pix_byte;

  assign h_last    = (int'(hcnt_q) == LINE - 1);
  assign v_last    = (int'(vcnt_q) == lines_of(state_q) - 1);
  assign nxt_st    = first_nonempty(succ(state_q));
  assign frame_end = (state_q != IDLE) && h_last && v_last && (nxt_st == IDLE);
  assign href_d    = (state_q == ACTIVE) && (int'(hcnt_q) < ACT);
  assign pix_x     = 8'(int'(hcnt_q) / bytes_per_pixel);
  assign pix_y     = 8'(vcnt_q);
  assign byte_sel  = ((int'(hcnt_q) % bytes_per_pixel) != 0);

  ov7670_pattern_pixel u_pix (
    .x_i         (pix_x),
    .y_i         (pix_y),
    .byte_sel_i  (byte_sel),
    .mode_i      (mode_q),
    .frame_cnt_i (frame_cnt_q),
    .byte_o      (pix_byte)
  );

  // Frame sequencer, line/byte counters and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= RAMP_H;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frame_cnt_q  <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      dout_q       <= 8'h00;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      vsync_q      <= (state_q == VSYNC);
      href_q       <= href_d;
      dout_q       <= href_d ? pix_byte : 8'h00;
      frame_done_q <= frame_end;
      busy_q       <= (state_q != IDLE);
      // Count advances the cycle after the done pulse is visible.
      if (frame_done_q) frame_cnt_q <= frame_cnt_q + 8'd1;

      case (state_q)
        IDLE: begin
          hcnt_q <= '0;
          vcnt_q <= '0;
          if (dvp.enable) begin
            state_q <= FIRST_ST;
            mode_q  <= pattern_t'(dvp.mode);
          end
        end
        default: begin
          if (h_last) begin
            hcnt_q <= '0;
            if (v_last) begin
              vcnt_q <= '0;
              if (nxt_st != IDLE) begin
                state_q <= nxt_st;
              end else if (dvp.enable) begin
                state_q <= FIRST_ST;
                mode_q  <= pattern_t'(dvp.mode);
              end else begin
                state_q <= IDLE;
              end
            end else begin
              vcnt_q <= vcnt_q + VW'(1);
            end
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign dvp.vsync      = vsync_q;
  assign dvp.href       = href_q;
  assign dvp.dout       = dout_q;
  assign dvp.frame_cnt  = frame_cnt_q;
  assign dvp.frame_done = frame_done_q;
  assign dvp.busy       = busy_q;

endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Bench for ov7670_dvp_tx: byte scoreboard on a small-frame instance plus a
// second instance (wider lines, no back porch) for the checkerboard pattern.
module tb_ov7670_dvp_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ov7670_dvp_tx_if if1 ();
  ov7670_dvp_tx_if if2 ();

  ov7670_dvp_tx #(
    .h_active(8), .h_blank(4), .bytes_per_pixel(2),
    .v_sync_lines(1), .v_back_lines(1), .v_active(4), .v_front_lines(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dvp   (if1)
  );

  ov7670_dvp_tx #(
    .h_active(16), .h_blank(4), .bytes_per_pixel(2),
    .v_sync_lines(1), .v_back_lines(0), .v_active(16), .v_front_lines(1)
  ) dut_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .dvp   (if2)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  function automatic logic [7:0] y_model(int m, int x, int y, int fc);
    logic [7:0] xb, yb, fb;
    xb = x[7:0];
    yb = y[7:0];
    fb = fc[7:0];
    case (m)
      0:       return xb;
      1:       return yb;
      2:       return (xb[3] ^ yb[3]) ? 8'hFF : 8'h00;
      default: return fb;
    endcase
  endfunction

  task automatic push_frame(input int m, input int fc);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        exp_q.push_back(y_model(m, x, y, fc));
        exp_q.push_back(8'h80);
      end
  endtask

  // Scoreboard on the small instance: every href byte must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (if1.href === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL byte_unexpected got=%h required=none", if1.dout);
        end else begin
          exp_byte = exp_q.pop_front();
          if (if1.dout !== exp_byte) begin
            bad++;
            $display("FAIL byte got=%h required=%h", if1.dout, exp_byte);
          end
        end
      end else if (if1.dout !== 8'h00) begin
        bad++;
        $display("FAIL dout_blank got=%h required=00", if1.dout);
      end
    end
  end

  int k_vs, vs_cnt, k_href, href_cnt, k_done, done_cnt, busy_cnt, fc_at_done, fc_after;

  task automatic watch(input int n);
    logic prev_done;
    prev_done = 1'b0;
    k_vs = -1; vs_cnt = 0; k_href = -1; href_cnt = 0;
    k_done = -1; done_cnt = 0; busy_cnt = 0; fc_at_done = -1; fc_after = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (if1.vsync === 1'b1) begin if (k_vs < 0) k_vs = k; vs_cnt++; end
      if (if1.href === 1'b1) begin if (k_href < 0) k_href = k; href_cnt++; end
      if (if1.busy === 1'b1) busy_cnt++;
      if (prev_done && fc_after < 0) fc_after = int'(if1.frame_cnt);
      if (if1.frame_done === 1'b1) begin
        if (k_done < 0) begin k_done = k; fc_at_done = int'(if1.frame_cnt); end
        done_cnt++;
      end
      prev_done = (if1.frame_done === 1'b1);
    end
  endtask

  task automatic test_reset();
    int nz;
    rst_n = 1'b0;
    if1.enable = 1'b0; if1.mode = 2'd0;
    if2.enable = 1'b0; if2.mode = 2'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if ({if1.vsync, if1.href, if1.dout, if1.frame_cnt, if1.frame_done, if1.busy} !== 20'd0) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL idle_outputs nonzero_cycles=%0d required=0", nz); end
    total++; if (if1.vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync got=%b required=0", if1.vsync); end
    total++; if (if1.href !== 1'b0) begin bad++; $display("FAIL reset_href got=%b required=0", if1.href); end
    total++; if (if1.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h required=00", if1.dout); end
    total++; if (if1.frame_cnt !== 8'h00) begin bad++; $display("FAIL reset_fcnt got=%h required=00", if1.frame_cnt); end
    total++; if (if1.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required=0", if1.frame_done); end
    total++; if (if1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", if1.busy); end
  endtask

  task automatic test_single_frame();
    push_frame(0, 0);
    @(negedge clk); if1.mode = 2'd0; if1.enable = 1'b1;
    @(negedge clk); if1.enable = 1'b0;
    watch(200);
    total++; if (k_vs !== 0) begin bad++; $display("FAIL sf_vsync_start got=%0d required=0", k_vs); end
    total++; if (vs_cnt !== 24) begin bad++; $display("FAIL sf_vsync_len got=%0d required=24", vs_cnt); end
    total++; if (k_href - k_vs !== 48) begin bad++; $display("FAIL sf_href_delay got=%0d required=48", k_href - k_vs); end
    total++; if (href_cnt !== 64) begin bad++; $display("FAIL sf_href_bytes got=%0d required=64", href_cnt); end
    total++; if (k_done !== 167) begin bad++; $display("FAIL sf_done_time got=%0d required=167", k_done); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL sf_done_count got=%0d required=1", done_cnt); end
    total++; if (fc_at_done !== 0) begin bad++; $display("FAIL sf_fcnt_at_done got=%0d required=0", fc_at_done); end
    total++; if (fc_after !== 1) begin bad++; $display("FAIL sf_fcnt_after got=%0d required=1", fc_after); end
    total++; if (busy_cnt !== 168) begin bad++; $display("FAIL sf_busy_len got=%0d required=168", busy_cnt); end
    total++; if (if1.busy !== 1'b0) begin bad++; $display("FAIL sf_idle got=%b required=0", if1.busy); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sf_bytes_left got=%0d required=0", exp_q.size()); end
  endtask

  // Two frames back to back; mode flips mid-frame 1 and enable drops mid-frame 2.
  task automatic test_back_to_back();
    int k, dn, nrise, rise0, rise1;
    logic changed, prev_vs;
    push_frame(0, 1);
    push_frame(1, 2);
    @(negedge clk); if1.mode = 2'd0; if1.enable = 1'b1;
    k = 0; dn = 0; nrise = 0; rise0 = -1; rise1 = -1; changed = 1'b0; prev_vs = 1'b0;
    while (k < 600 && !(dn >= 2 && if1.busy === 1'b0)) begin
      @(negedge clk);
      if (if1.vsync === 1'b1 && !prev_vs) begin
        if (nrise == 0) rise0 = k; else if (nrise == 1) rise1 = k;
        nrise++;
      end
      prev_vs = (if1.vsync === 1'b1);
      if (if1.href === 1'b1 && !changed) begin if1.mode = 2'd1; changed = 1'b1; end
      if (if1.frame_done === 1'b1) dn++;
      if (dn == 1 && if1.href === 1'b1) if1.enable = 1'b0;
      k++;
    end
    total++; if (k >= 600) begin bad++; $display("FAIL b2b_timeout cycles=%0d required<600", k); end
    total++; if (nrise !== 2) begin bad++; $display("FAIL b2b_vsync_rises got=%0d required=2", nrise); end
    total++; if (rise1 - rise0 !== 168) begin bad++; $display("FAIL b2b_frame_period got=%0d required=168", rise1 - rise0); end
    total++; if (dn !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d required=2", dn); end
    repeat (2) @(negedge clk);
    total++; if (if1.frame_cnt !== 8'd3) begin bad++; $display("FAIL b2b_fcnt got=%0d required=3", if1.frame_cnt); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_bytes_left got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int k, nh;
    push_frame(0, 3);
    @(negedge clk); if1.mode = 2'd0; if1.enable = 1'b1;
    k = 0; nh = 0;
    while (k < 300 && nh < 10) begin
      @(negedge clk);
      if (if1.href === 1'b1) nh++;
      k++;
    end
    total++; if (nh !== 10) begin bad++; $display("FAIL rst_reach_active got=%0d required=10", nh); end
    rst_n = 1'b0; if1.enable = 1'b0;
    @(posedge clk); #1;
    total++; if ({if1.vsync, if1.href, if1.frame_done, if1.busy} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b required=0000", {if1.vsync, if1.href, if1.frame_done, if1.busy});
    end
    total++; if (if1.dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h required=00", if1.dout); end
    total++; if (if1.frame_cnt !== 8'h00) begin bad++; $display("FAIL rst_fcnt got=%h required=00", if1.frame_cnt); end
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    int k, dn, y255, y256, fc_wrap;
    logic prev_done;
    for (int f = 0; f < 257; f++) push_frame(3, f % 256);
    @(negedge clk); if1.mode = 2'd3; if1.enable = 1'b1;
    k = 0; dn = 0; y255 = -1; y256 = -1; fc_wrap = -1; prev_done = 1'b0;
    while (k < 45000 && !(dn >= 257 && if1.busy === 1'b0)) begin
      @(negedge clk);
      if (prev_done && dn == 256 && fc_wrap < 0) fc_wrap = int'(if1.frame_cnt);
      if (if1.href === 1'b1) begin
        if (dn == 255 && y255 < 0) y255 = int'(if1.dout);
        if (dn == 256 && y256 < 0) y256 = int'(if1.dout);
        if (dn == 256) if1.enable = 1'b0;
      end
      if (if1.frame_done === 1'b1) dn++;
      prev_done = (if1.frame_done === 1'b1);
      k++;
    end
    total++; if (k >= 45000) begin bad++; $display("FAIL wrap_timeout cycles=%0d required<45000", k); end
    total++; if (dn !== 257) begin bad++; $display("FAIL wrap_done_count got=%0d required=257", dn); end
    total++; if (y255 !== 255) begin bad++; $display("FAIL wrap_y_frame255 got=%0d required=255", y255); end
    total++; if (fc_wrap !== 0) begin bad++; $display("FAIL wrap_fcnt got=%0d required=0", fc_wrap); end
    total++; if (y256 !== 0) begin bad++; $display("FAIL wrap_y_frame256 got=%0d required=0", y256); end
    repeat (2) @(negedge clk);
    total++; if (if1.frame_cnt !== 8'd1) begin bad++; $display("FAIL wrap_fcnt_end got=%0d required=1", if1.frame_cnt); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL wrap_bytes_left got=%0d required=0", exp_q.size()); end
  endtask

  // Checkerboard on the 16x16 instance; its back porch is zero lines, so href follows vsync by one line.
  task automatic test_checker();
    logic [7:0] ymap [16][16];
    int kv, kh, nb, ny, cbad, mbad, idx;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) ymap[r][c] = 8'h55;
    if2.mode = 2'd2;
    @(negedge clk); if2.enable = 1'b1;
    @(negedge clk); if2.enable = 1'b0;
    kv = -1; kh = -1; nb = 0; ny = 0; cbad = 0; mbad = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (if2.vsync === 1'b1 && kv < 0) kv = k;
      if (if2.href === 1'b1) begin
        if (kh < 0) kh = k;
        if (nb % 2 == 0) begin
          idx = nb / 2;
          if (idx / 16 < 16) ymap[idx / 16][idx % 16] = if2.dout;
          ny++;
        end else if (if2.dout !== 8'h80) cbad++;
        nb++;
      end
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (ymap[r][c] !== y_model(2, c, r, 0)) mbad++;
    total++; if (kh - kv !== 40) begin bad++; $display("FAIL chk_href_delay got=%0d required=40", kh - kv); end
    total++; if (ny !== 256) begin bad++; $display("FAIL chk_y_count got=%0d required=256", ny); end
    total++; if (cbad !== 0) begin bad++; $display("FAIL chk_chroma bad=%0d required=0", cbad); end
    total++; if (ymap[0][7] !== 8'h00) begin bad++; $display("FAIL chk_7_0 got=%h required=00", ymap[0][7]); end
    total++; if (ymap[0][8] !== 8'hFF) begin bad++; $display("FAIL chk_8_0 got=%h required=ff", ymap[0][8]); end
    total++; if (ymap[8][8] !== 8'h00) begin bad++; $display("FAIL chk_8_8 got=%h required=00", ymap[8][8]); end
    total++; if (mbad !== 0) begin bad++; $display("FAIL chk_map wrong=%0d required=0", mbad); end
    total++; if (if2.busy !== 1'b0 || if2.frame_cnt !== 8'd1) begin
      bad++; $display("FAIL chk_end busy=%b fcnt=%0d required busy=0 fcnt=1", if2.busy, if2.frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    test_checker();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_dvp_tx.md
# ov7670_dvp_tx

Synthesizable OV7670 parallel-port (DVP) transmitter: generates VSYNC/HREF/D[7:0] with OV7670 VGA YUV422 frame timing and a selectable test pattern. It is the sending end of the camera pixel interface consumed by `ov7670_capture`. It is used to bring up and regress the capture → `fb1` → `core` → LeNet path on the board or in simulation without a physical sensor.

## Interface

Parameters:
- `h_active`, 640, active pixels per line
- `h_blank`, 144, blank pixels per line (HREF low)
- `bytes_per_pixel`, 2, bytes per pixel: YUV422, Y byte first, then chroma byte 8'h80
- `v_sync_lines`, 3, lines with VSYNC high
- `v_back_lines`, 17, blank lines after VSYNC
- `v_active`, 480, active lines
- `v_front_lines`, 10, blank lines after the active region

Ports:
- `clk`  in  1  byte clock; the consumer's PCLK is this clock, inverted at board/bench level
- `rst_n`  in  1  reset; **synchronous, active-low**
- `enable`  in  1  run frames while high
- `mode`  in  2  pattern select, sampled at frame start
- `vsync`  out  1  OV7670_VSYNC equivalent, active high
- `href`  out  1  OV7670_HREF equivalent, high during active bytes
- `dout`  out  8  OV7670_D equivalent
- `frame_cnt`  out  8  completed frames, wraps at 255→0
- `frame_done`  out  1  one-cycle pulse at the end of each frame
- `busy`  out  1  high when the state is not IDLE

## Operation

- Derived quantities:
  - LINE = (h_active + h_blank) × bytes_per_pixel = 1568 cycles.
  - ACT = h_active × bytes_per_pixel = 1280 cycles.
- Counters:
  - `hcnt` runs 0..LINE-1 with width $clog2(LINE).
  - `vcnt` counts lines within the current state.
- State machine:
  - IDLE → VSYNC when `enable`=1. `mode` is latched on this transition.
  - VSYNC (v_sync_lines lines) → VBACK (v_back_lines lines) → ACTIVE (v_active lines) → VFRONT (v_front_lines lines).
  - At the end of VFRONT, go to VSYNC if `enable`=1, otherwise to IDLE. `mode` is relatched on the VSYNC entry.
- Output behaviour by state:
  - `vsync`=1 only in VSYNC.
  - `href`=1 only in ACTIVE with hcnt < ACT.
  - `dout`=0 whenever `href`=0.
- Pixel coordinates, valid during ACTIVE: x = hcnt / bytes_per_pixel; y = vcnt.
- Byte selection: even byte = Y, odd byte = 8'h80.
- Y value by latched `mode`:
  - 0: x[7:0] (horizontal ramp)
  - 1: {y[7:0]} (vertical ramp)
  - 2: (x[3] ^ y[3]) ? 8'hFF : 8'h00 (8×8 checkerboard)
  - 3: `frame_cnt` (solid, changes each frame)
- End of frame (last cycle of VFRONT):
  - `frame_done` pulses.
  - `frame_cnt` increments modulo 256.
- Boundary conditions:
  - `enable` deasserted mid-frame: the current frame completes in full. Partial frames are never emitted.
  - `mode` change mid-frame: ignored until the next VSYNC entry.
  - Any `v_*_lines` = 0: that state is skipped, with no idle cycle inserted.
  - `rst_n`=0 mid-frame: all outputs are back to reset values on the next clk edge.

## Timing

- All outputs are registered on the rising edge of `clk`.
- Reset values: `vsync`=0, `href`=0, `dout`=0, `frame_cnt`=0, `frame_done`=0, `busy`=0. State is IDLE.
- Start latency: `enable` sampled high at edge N gives `vsync`=1 and `busy`=1 after edge N+1.
- VSYNC high time: exactly v_sync_lines × LINE cycles.
- First active line: the first `href` rise comes (v_sync_lines + v_back_lines) × LINE cycles after the `vsync` rise.
- Per active line: `href` is high for ACT consecutive cycles, then low for LINE-ACT cycles. The first byte (Y of x=0) coincides with the `href` rise.
- Frame period with default parameters: 510 × 1568 = 799,680 cycles.
- Back-to-back frames: there are no idle cycles between the end of VFRONT and VSYNC.
- `frame_done` is coincident with the last VFRONT cycle. `frame_cnt` shows the new value on the following cycle.

## Structure

- `ov7670_dvp_pkg` holds:
  - the `state_t` enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT)
  - the `pattern_t` enum (RAMP_H, RAMP_V, CHECKER, SOLID_FCNT)
  - the constant CHROMA = 8'h80
- Sub-module `ov7670_pattern_pixel` is combinational. Inputs: x, y, byte_sel, mode, frame_cnt. Output: byte. The top registers its output into `dout`.
- Timing FSM and counters live in the top module.

## Test plan

Benches use reduced parameters (h_active=8, h_blank=4, bytes_per_pixel=2, v_sync_lines=1, v_back_lines=1, v_active=4, v_front_lines=1; LINE=24) unless noted.

- Reset/idle: hold `rst_n`=0, then release with `enable`=0 for 100 cycles → all outputs stay 0 and `busy`=0.
- Single frame: pulse `enable` for 1 cycle with `mode`=0 →
  - `vsync` high 24 cycles.
  - `href` rises 48 cycles after the `vsync` rise.
  - 4 lines of 16 bytes each: 00,80,01,80,…,07,80.
  - `frame_done` at cycle 168.
  - `frame_cnt`=1.
  - Returns to IDLE.
- Checkerboard: `mode`=2, default parameters, with a capture model attached → Y at (7,0)=00, (8,0)=FF, (8,8)=00. The capture receives 307,200 Y bytes.
- Mid-frame `mode` change: set `mode` 0→1 during ACTIVE → the current frame stays a horizontal ramp; the next frame line y carries Y=y.
- `enable` drop mid-frame, then mid-frame reset:
  - Drop `enable` during ACTIVE → the frame completes, `frame_done` pulses once, then IDLE.
  - Assert `rst_n`=0 during a later frame → outputs are zero one edge later.
- Counter wrap: run 256 frames with `mode`=3 → frame 255 Y=FF, then `frame_cnt` wraps to 0 and the next frame's Y=00.
